// File: rtl/pong_pkg.sv
// Shared encodings for the pong game-flow controller and downstream ball/score stage.
package pong_pkg;

    localparam int unsigned GS_W  = 2;
    localparam int unsigned WIN_W = 2;

    localparam logic [GS_W-1:0] GS_IDLE = 2'b00;
    localparam logic [GS_W-1:0] GS_PLAY = 2'b01;
    localparam logic [GS_W-1:0] GS_HOLD = 2'b10;
    localparam logic [GS_W-1:0] GS_OVER = 2'b11;

    localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
    localparam logic [WIN_W-1:0] WIN_P1   = 2'b01;
    localparam logic [WIN_W-1:0] WIN_P2   = 2'b10;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Externally visible game_state for an internal FSM state; SERVE and PAUSE share HOLD.
    function automatic logic [GS_W-1:0] gs_of(input state_t s);
        logic [GS_W-1:0] gs;
        gs = GS_IDLE;
        case (s)
            ST_SERVE, ST_PAUSE: gs = GS_HOLD;
            ST_PLAY:            gs = GS_PLAY;
            ST_OVER:            gs = GS_OVER;
            default:            gs = GS_IDLE;
        endcase
        return gs;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge press pulse for one raw button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic clk_1ms,
    input  logic reset,
    input  logic btn,
    output logic press_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_MS + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Level flips only after the synchronised input disagrees for DEBOUNCE_MS cycles.
    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            level_d <= level;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press_c = level & ~level_d;

endmodule

// File: rtl/pong_game_ctrl.sv
// Match flow controller: debounced start/pause, serve delay, score watch and winner detection.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned SERVE_MS    = 1000,
    parameter int unsigned WIN_SCORE   = 9
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic [3:0] p1_score,
    input  logic [3:0] p2_score,
    output logic [1:0] game_state,
    output logic [1:0] winner,
    output logic       round_rst_n
);

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned SERVE_W = (SERVE_MS > 1) ? $clog2(SERVE_MS) : 1;
    localparam logic [SCORE_W-1:0] WIN_LVL = SCORE_W'(WIN_SCORE);

    logic start_p;
    logic pause_p;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_db (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn     (btn_start),
        .press_c (start_p)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_pause_db (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn     (btn_pause),
        .press_c (pause_p)
    );

    state_t               state, state_nxt;
    logic [SERVE_W-1:0]   serve_cnt, serve_cnt_nxt;
    logic [SCORE_W-1:0]   snap1, snap1_nxt;
    logic [SCORE_W-1:0]   snap2, snap2_nxt;
    logic [WIN_W-1:0]     winner_nxt;
    logic                 rrst_nxt;

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            state       <= ST_IDLE;
            game_state  <= GS_IDLE;
            winner      <= WIN_NONE;
            round_rst_n <= 1'b1;
            serve_cnt   <= '0;
            snap1       <= p1_score;
            snap2       <= p2_score;
        end else begin
            state       <= state_nxt;
            game_state  <= gs_of(state_nxt);
            winner      <= winner_nxt;
            round_rst_n <= rrst_nxt;
            serve_cnt   <= serve_cnt_nxt;
            snap1       <= snap1_nxt;
            snap2       <= snap2_nxt;
        end
    end

    // Next state; a win or point in PLAY outranks a same-cycle pause press.
    always_comb begin
        state_nxt     = state;
        winner_nxt    = winner;
        rrst_nxt      = 1'b1;
        serve_cnt_nxt = serve_cnt;
        snap1_nxt     = snap1;
        snap2_nxt     = snap2;
        unique case (state)
            ST_IDLE: begin
                if (start_p) begin
                    rrst_nxt  = 1'b0;
                    state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (serve_cnt == SERVE_W'(SERVE_MS - 1)) begin
                    serve_cnt_nxt = '0;
                    state_nxt     = ST_PLAY;
                end else begin
                    serve_cnt_nxt = serve_cnt + 1'b1;
                end
            end
            ST_PLAY: begin
                if (p1_score >= WIN_LVL) begin
                    winner_nxt = WIN_P1;
                    state_nxt  = ST_OVER;
                end else if (p2_score >= WIN_LVL) begin
                    winner_nxt = WIN_P2;
                    state_nxt  = ST_OVER;
                end else if ((p1_score != snap1) || (p2_score != snap2)) begin
                    snap1_nxt = p1_score;
                    snap2_nxt = p2_score;
                    state_nxt = ST_SERVE;
                end else if (pause_p) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_p) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_p) begin
                    winner_nxt = WIN_NONE;
                    rrst_nxt   = 1'b0;
                    snap1_nxt  = '0;
                    snap2_nxt  = '0;
                    state_nxt  = ST_SERVE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed scoreboard bench for pong_game_ctrl with default timing parameters.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic       clk_1ms = 1'b0;
    logic       reset;
    logic       btn_start;
    logic       btn_pause;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] game_state;
    logic [1:0] winner;
    logic       round_rst_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] gs;
        logic [1:0] win;
        logic       rr;
    } exp_t;

    exp_t sb[$];

    pong_game_ctrl dut (
        .clk_1ms     (clk_1ms),
        .reset       (reset),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .game_state  (game_state),
        .winner      (winner),
        .round_rst_n (round_rst_n)
    );

    always #5 clk_1ms = ~clk_1ms;

    initial begin
        repeat (30000) @(posedge clk_1ms);
        $display("FAIL watchdog expired game_state=%b", game_state);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_1ms);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input string tag, input logic [1:0] gs, input logic [1:0] win, input logic rr);
        exp_t e;
        e.tag = tag;
        e.gs  = gs;
        e.win = win;
        e.rr  = rr;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (game_state === e.gs) else begin
            errors++;
            $error("FAIL %s game_state got %b expected %b", e.tag, game_state, e.gs);
        end
        checks++;
        assert (winner === e.win) else begin
            errors++;
            $error("FAIL %s winner got %b expected %b", e.tag, winner, e.win);
        end
        checks++;
        assert (round_rst_n === e.rr) else begin
            errors++;
            $error("FAIL %s round_rst_n got %b expected %b", e.tag, round_rst_n, e.rr);
        end
    endtask

    initial begin
        reset = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
        p1_score = 4'd0; p2_score = 4'd0;
        ticks(3);
        push("reset", GS_IDLE, WIN_NONE, 1'b1); check();
        reset = 1'b1;

        // short start glitch is rejected
        btn_start = 1'b1; push("glitch_idle", GS_IDLE, WIN_NONE, 1'b1);
        ticks(10); btn_start = 1'b0; ticks(40); check();

        // start press: round reset at edge 23, serve 1000 cycles, then play
        btn_start = 1'b1;
        push("start_pre", GS_IDLE, WIN_NONE, 1'b1); ticks(22); check();
        push("start_rr_low", GS_HOLD, WIN_NONE, 1'b0); tick(); check();
        push("start_rr_high", GS_HOLD, WIN_NONE, 1'b1); tick(); check();
        ticks(6); btn_start = 1'b0;
        push("serve_last", GS_HOLD, WIN_NONE, 1'b1); ticks(992); check();
        push("serve_done", GS_PLAY, WIN_NONE, 1'b1); tick(); check();

        // p2 point -> serve -> play, snapshot follows
        p2_score = 4'd1;
        push("p2_point", GS_HOLD, WIN_NONE, 1'b1); tick(); check();
        push("p2_serve_last", GS_HOLD, WIN_NONE, 1'b1); ticks(999); check();
        push("p2_serve_done", GS_PLAY, WIN_NONE, 1'b1); tick(); check();
        push("snap_held", GS_PLAY, WIN_NONE, 1'b1); ticks(5); check();

        // pause toggle in play
        btn_pause = 1'b1;
        push("pause_pre", GS_PLAY, WIN_NONE, 1'b1); ticks(22); check();
        push("pause_on", GS_HOLD, WIN_NONE, 1'b1); tick(); check();
        ticks(7); btn_pause = 1'b0; ticks(30);
        push("paused_held", GS_HOLD, WIN_NONE, 1'b1); check();
        btn_pause = 1'b1;
        push("unpause_pre", GS_HOLD, WIN_NONE, 1'b1); ticks(22); check();
        push("unpause", GS_PLAY, WIN_NONE, 1'b1); tick(); check();
        ticks(7); btn_pause = 1'b0; ticks(30);
        push("play_after_pause", GS_PLAY, WIN_NONE, 1'b1); check();

        // pause during serve is ignored and does not stretch the serve
        p1_score = 4'd1;
        push("p1_point", GS_HOLD, WIN_NONE, 1'b1); tick(); check();
        btn_pause = 1'b1;
        push("serve_pause_ign", GS_HOLD, WIN_NONE, 1'b1); ticks(23); check();
        ticks(6); btn_pause = 1'b0; ticks(30);
        push("serve_pause_last", GS_HOLD, WIN_NONE, 1'b1); ticks(940); check();
        push("serve_pause_done", GS_PLAY, WIN_NONE, 1'b1); tick(); check();

        // p1 wins, then restart clears winner and snapshots
        p1_score = 4'd9;
        push("p1_win", GS_OVER, WIN_P1, 1'b1); tick(); check();
        push("over_held", GS_OVER, WIN_P1, 1'b1); ticks(5); check();
        btn_start = 1'b1;
        push("restart_pre", GS_OVER, WIN_P1, 1'b1); ticks(22); check();
        push("restart_rr", GS_HOLD, WIN_NONE, 1'b0); tick(); check();
        p1_score = 4'd0; p2_score = 4'd0;
        push("restart_rr_hi", GS_HOLD, WIN_NONE, 1'b1); tick(); check();
        ticks(6); btn_start = 1'b0; ticks(30);
        push("restart_serve_last", GS_HOLD, WIN_NONE, 1'b1); ticks(962); check();
        push("restart_play", GS_PLAY, WIN_NONE, 1'b1); tick(); check();
        push("restart_snap0", GS_PLAY, WIN_NONE, 1'b1); tick(); check();

        // one-cycle reset mid-play
        reset = 1'b0;
        push("mid_reset", GS_IDLE, WIN_NONE, 1'b1); tick(); check();
        reset = 1'b1;
        btn_start = 1'b1; ticks(22);
        push("t6_start", GS_HOLD, WIN_NONE, 1'b0); tick(); check();
        ticks(6); btn_start = 1'b0; ticks(30);
        push("t6_play", GS_PLAY, WIN_NONE, 1'b1); ticks(964); check();

        // pause press and score change in the same cycle: serve wins
        btn_pause = 1'b1; ticks(22); p1_score = 4'd1;
        push("pause_vs_score", GS_HOLD, WIN_NONE, 1'b1); tick(); check();
        ticks(6); btn_pause = 1'b0; ticks(30);
        push("score_pause_last", GS_HOLD, WIN_NONE, 1'b1); ticks(963); check();
        push("score_pause_play", GS_PLAY, WIN_NONE, 1'b1); tick(); check();

        // both reach the win score together: player 1 takes it
        p1_score = 4'd9; p2_score = 4'd9;
        push("both_win", GS_OVER, WIN_P1, 1'b1); tick(); check();

        // restart and let player 2 win
        btn_start = 1'b1; ticks(22);
        push("t7_restart", GS_HOLD, WIN_NONE, 1'b0); tick(); check();
        p1_score = 4'd0; p2_score = 4'd0;
        ticks(6); btn_start = 1'b0; ticks(30);
        push("t7_play", GS_PLAY, WIN_NONE, 1'b1); ticks(964); check();
        p2_score = 4'd10;
        push("p2_win", GS_OVER, WIN_P2, 1'b1); tick(); check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
